// File: rtl/da_gemm_stream.sv
// Streaming distributed-arithmetic GEMM tile engine.
// A tile A[M][K] x B[K][N] + bias[N] is accepted on a valid/ready port. Each
// B column is folded into a 2^K-entry LUT of partial column sums. Each A row is
// then evaluated bit-serially over DATA_WIDTH_A cycles. The result row is
// rounded, saturated and offered on a valid/ready output port.
// Flat port packing:
//   A[m][k]    at bits (m*K+k)*DATA_WIDTH_A
//   B[k][n]    at bits (k*N+n)*DATA_WIDTH_B
//   bias[n]    at bits n*DATA_WIDTH_bias
//   final_out  element n at bits n*DATA_WIDTH_out
module da_gemm_stream #(
  parameter int DATA_WIDTH_A    = 8,
  parameter int DATA_WIDTH_B    = 8,
  parameter int DATA_WIDTH_bias = 8,
  parameter int DATA_WIDTH_out  = 8,
  parameter int M               = 2,
  parameter int N               = 4,
  parameter int K               = 4,
  parameter int OUT_SHIFT       = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   soft_clr,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [M*K*DATA_WIDTH_A-1:0]            A,
  input  logic [K*N*DATA_WIDTH_B-1:0]            B,
  input  logic [N*DATA_WIDTH_bias-1:0]           bias,
  input  logic                                   bias_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]   out_row,
  output logic [N*DATA_WIDTH_out-1:0]            final_out,
  output logic                                   sat_flag
);

  localparam int ACC_W = DATA_WIDTH_A + DATA_WIDTH_B + $clog2(K) + 2;
  localparam int RW    = ACC_W + 1;
  localparam int MW    = (M > 1) ? $clog2(M) : 1;
  localparam int TW    = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam int LN    = 1 << K;
  localparam int SH_M1 = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND  = (OUT_SHIFT > 0) ? $signed(RW'(64'd1 << SH_M1)) : '0;
  localparam logic signed [RW-1:0] OMAX = $signed(RW'((64'd1 << (DATA_WIDTH_out - 1)) - 64'd1));
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT} state_t;

  state_t                       state, state_nxt;
  logic [MW-1:0]                m_cnt;
  logic [TW-1:0]                t_cnt;
  logic [M*K*DATA_WIDTH_A-1:0]  a_reg;
  logic [N*DATA_WIDTH_bias-1:0] bias_reg;
  logic signed [ACC_W-1:0]      lut     [N][LN];
  logic signed [ACC_W-1:0]      lut_nxt [N][LN];
  logic signed [ACC_W-1:0]      term_p0 [N];
  logic signed [ACC_W-1:0]      acc_nxt [N];
  logic signed [ACC_W-1:0]      acc_p1  [N];
  logic [K-1:0]                 addr_p0;
  logic [N*DATA_WIDTH_out-1:0]  fo_nxt;
  logic                         any_sat;
  logic                         accept;
  logic                         last_bit;

  // Round half up, then arithmetic shift right by OUT_SHIFT.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [RW-1:0] r);
    round_shift = (r + RND) >>> OUT_SHIFT;
  endfunction

  // Clamp to the signed output range.
  function automatic logic [DATA_WIDTH_out-1:0] sat_out(input logic signed [RW-1:0] v);
    if (v > OMAX)      sat_out = OMAX[DATA_WIDTH_out-1:0];
    else if (v < OMIN) sat_out = OMIN[DATA_WIDTH_out-1:0];
    else               sat_out = v[DATA_WIDTH_out-1:0];
  endfunction

  // Flag whether a value falls outside the signed output range.
  function automatic logic is_sat(input logic signed [RW-1:0] v);
    is_sat = (v > OMAX) || (v < OMIN);
  endfunction

  assign in_ready = (state == S_IDLE);
  assign accept   = (state == S_IDLE) && in_valid && !soft_clr;
  assign last_bit = (t_cnt == TW'(DATA_WIDTH_A - 1));

  // LUT contents for the presented B: per column, the sum of the selected rows.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < LN; a++) begin
        logic signed [ACC_W-1:0] s;
        s = '0;
        for (int k = 0; k < K; k++) begin
          if (((a >> k) & 1) == 1)
            s = s + ACC_W'($signed(B[(k*N+n)*DATA_WIDTH_B +: DATA_WIDTH_B]));
        end
        lut_nxt[n][a] = s;
      end
    end
  end

  // ---- stage p0: gather bit t of each A[m][k] into the LUT address ----
  always_comb begin
    addr_p0 = '0;
    for (int k = 0; k < K; k++)
      addr_p0[k] = a_reg[(int'(m_cnt)*K + k)*DATA_WIDTH_A + int'(t_cnt)];
  end

  // Per-column shifted partial term and accumulator update.
  // The top bit carries negative weight in two's complement.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      logic signed [ACC_W-1:0] base;
      term_p0[n] = lut[n][addr_p0] <<< t_cnt;
      base       = (t_cnt == '0) ? '0 : acc_p1[n];
      acc_nxt[n] = last_bit ? (base - term_p0[n]) : (base + term_p0[n]);
    end
  end

  // ---- stage p1: accumulated row feeds bias, rounding and saturation ----
  always_comb begin
    fo_nxt  = '0;
    any_sat = 1'b0;
    for (int n = 0; n < N; n++) begin
      logic signed [RW-1:0] r;
      logic signed [RW-1:0] rs;
      r  = RW'(acc_p1[n]) + RW'($signed(bias_reg[n*DATA_WIDTH_bias +: DATA_WIDTH_bias]));
      rs = round_shift(r);
      fo_nxt[n*DATA_WIDTH_out +: DATA_WIDTH_out] = sat_out(rs);
      any_sat = any_sat | is_sat(rs);
    end
  end

  // Datapath registers: tile capture, LUT build, and bit-serial accumulation.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg    <= A;
      bias_reg <= bias_en ? bias : '0;
      for (int n = 0; n < N; n++)
        for (int a = 0; a < LN; a++)
          lut[n][a] <= lut_nxt[n][a];
    end
    for (int n = 0; n < N; n++) begin
      if (soft_clr)                acc_p1[n] <= '0;
      else if (state == S_COMPUTE) acc_p1[n] <= acc_nxt[n];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; soft_clr overrides every transition.
  always_comb begin
    state_nxt = state;
    if (soft_clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (in_valid) state_nxt = S_COMPUTE;
        S_COMPUTE: if (last_bit) state_nxt = S_OUTPUT;
        S_OUTPUT:  if (out_valid && out_ready)
                     state_nxt = (m_cnt == MW'(M - 1)) ? S_IDLE : S_COMPUTE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, output row register, and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= '0;
      t_cnt     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      final_out <= '0;
      sat_flag  <= 1'b0;
    end else if (soft_clr) begin
      m_cnt     <= '0;
      t_cnt     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            m_cnt    <= '0;
            t_cnt    <= '0;
            sat_flag <= 1'b0;
          end
        end
        S_COMPUTE: begin
          t_cnt <= last_bit ? '0 : t_cnt + 1'b1;
        end
        S_OUTPUT: begin
          if (!out_valid) begin
            final_out <= fo_nxt;
            out_row   <= m_cnt;
            out_valid <= 1'b1;
            if (any_sat) sat_flag <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            t_cnt     <= '0;
            m_cnt     <= (m_cnt == MW'(M - 1)) ? '0 : m_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_gemm_stream.sv
// Directed bench for da_gemm_stream with default geometry (M=2, N=4, K=4, 8-bit).
// A second instance with OUT_SHIFT=1 shares all inputs.
module tb_da_gemm_stream;

  logic        clk = 1'b0;
  logic        rst_n, soft_clr, in_valid, bias_en, out_ready;
  logic [63:0] A;
  logic [127:0] B;
  logic [31:0] bias;
  logic        in_ready, out_valid, sat_flag;
  logic [0:0]  out_row;
  logic [31:0] final_out;
  logic        in_ready_s, out_valid_s, sat_flag_s;
  logic [0:0]  out_row_s;
  logic [31:0] final_out_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  da_gemm_stream dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bias(bias), .bias_en(bias_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .final_out(final_out), .sat_flag(sat_flag)
  );

  da_gemm_stream #(.OUT_SHIFT(1)) dut_sh (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .bias(bias), .bias_en(bias_en), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_row(out_row_s), .final_out(final_out_s), .sat_flag(sat_flag_s)
  );

  function automatic logic [31:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int m, input int k, input int v);
    A[(m*4+k)*8 +: 8] = 8'(v);
  endtask

  task automatic set_b(input int k, input int n, input int v);
    B[(k*4+n)*8 +: 8] = 8'(v);
  endtask

  task automatic load_t1();
    set_a(0,0,1);  set_a(0,1,2); set_a(0,2,3); set_a(0,3,4);
    set_a(1,0,-1); set_a(1,1,0); set_a(1,2,0); set_a(1,3,5);
    for (int k = 0; k < 4; k++) for (int n = 0; n < 4; n++) set_b(k, n, 1);
    bias    = pk(9, 9, 9, 9);
    bias_en = 1'b0;
  endtask

  task automatic load_cols();
    set_a(0,0,1); set_a(0,1,-2); set_a(0,2,3); set_a(0,3,0);
    set_a(1,0,0); set_a(1,1,0);  set_a(1,2,0); set_a(1,3,-7);
    B = '0;
    for (int k = 0; k < 4; k++) set_b(k, 0, 1);
    set_b(0,1,2); set_b(1,2,1); set_b(2,3,-1); set_b(3,3,5);
    bias    = pk(10, -1, 2, 100);
    bias_en = 1'b1;
  endtask

  task automatic send_tile();
    for (int i = 0; i < 50 && !in_ready; i++) step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; bias_en = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; bias = '0;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (final_out !== 32'h0) begin n_bad++; $display("FAIL rst_final_out got %h want 0", final_out); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL rst_sat_flag got %b want 0", sat_flag); end
    n_cmp++; if (out_row !== 1'b0) begin n_bad++; $display("FAIL rst_out_row got %b want 0", out_row); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int e;
    load_t1();
    send_tile();
    wait_out(e);
    n_cmp++; if (e !== 9) begin n_bad++; $display("FAIL t1_latency got %0d want 9", e); end
    n_cmp++; if (final_out !== pk(10,10,10,10)) begin n_bad++; $display("FAIL t1_row0 got %h want %h", final_out, pk(10,10,10,10)); end
    n_cmp++; if (out_row !== 1'b0) begin n_bad++; $display("FAIL t1_row0_idx got %b want 0", out_row); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL t1_sat got %b want 0", sat_flag); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_valid_drop got %b want 0", out_valid); end
    wait_out(e);
    n_cmp++; if (e !== 9) begin n_bad++; $display("FAIL t1_row1_latency got %0d want 9", e); end
    n_cmp++; if (final_out !== pk(4,4,4,4)) begin n_bad++; $display("FAIL t1_row1 got %h want %h", final_out, pk(4,4,4,4)); end
    n_cmp++; if (out_row !== 1'b1) begin n_bad++; $display("FAIL t1_row1_idx got %b want 1", out_row); end
    handshake();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t1_idle got %b want 1", in_ready); end
  endtask

  task automatic test_bias_cols();
    int e;
    load_cols();
    send_tile();
    wait_out(e);
    n_cmp++; if (final_out !== pk(12,1,0,97)) begin n_bad++; $display("FAIL cols_row0 got %h want %h", final_out, pk(12,1,0,97)); end
    handshake();
    wait_out(e);
    n_cmp++; if (final_out !== pk(3,-1,2,65)) begin n_bad++; $display("FAIL cols_row1 got %h want %h", final_out, pk(3,-1,2,65)); end
    handshake();
  endtask

  task automatic test_sat();
    int e;
    for (int k = 0; k < 4; k++) begin
      set_a(0, k, -128); set_a(1, k, 127);
      for (int n = 0; n < 4; n++) set_b(k, n, -128);
    end
    bias_en = 1'b0;
    send_tile();
    wait_out(e);
    n_cmp++; if (final_out !== pk(127,127,127,127)) begin n_bad++; $display("FAIL sat_pos got %h want %h", final_out, pk(127,127,127,127)); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag_set got %b want 1", sat_flag); end
    handshake();
    wait_out(e);
    n_cmp++; if (final_out !== pk(-128,-128,-128,-128)) begin n_bad++; $display("FAIL sat_neg got %h want %h", final_out, pk(-128,-128,-128,-128)); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag_sticky got %b want 1", sat_flag); end
    handshake();
    load_t1();
    send_tile();
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_clear_on_accept got %b want 0", sat_flag); end
    wait_out(e);
    n_cmp++; if (final_out !== pk(10,10,10,10) || sat_flag !== 1'b0) begin
      n_bad++; $display("FAIL sat_clean_tile got %h/%b want %h/0", final_out, sat_flag, pk(10,10,10,10));
    end
    handshake();
    wait_out(e);
    handshake();
  endtask

  task automatic test_round();
    int e;
    A = '0; B = '0;
    set_a(0, 0, 2);
    for (int n = 0; n < 4; n++) set_b(0, n, 1);
    bias = pk(1, -5, 0, 0); bias_en = 1'b1;
    send_tile();
    wait_out(e);
    n_cmp++; if (final_out !== pk(3,-3,2,2)) begin n_bad++; $display("FAIL rnd_noshift_row0 got %h want %h", final_out, pk(3,-3,2,2)); end
    n_cmp++; if (final_out_s !== pk(2,-1,1,1)) begin n_bad++; $display("FAIL rnd_shift_row0 got %h want %h", final_out_s, pk(2,-1,1,1)); end
    handshake();
    wait_out(e);
    n_cmp++; if (final_out !== pk(1,-5,0,0)) begin n_bad++; $display("FAIL rnd_noshift_row1 got %h want %h", final_out, pk(1,-5,0,0)); end
    n_cmp++; if (final_out_s !== pk(1,-2,0,0)) begin n_bad++; $display("FAIL rnd_shift_row1 got %h want %h", final_out_s, pk(1,-2,0,0)); end
    handshake();
  endtask

  task automatic test_stall();
    int e;
    load_t1();
    send_tile();
    wait_out(e);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_row !== 1'b0 || final_out !== pk(10,10,10,10)) begin
        n_bad++; $display("FAIL stall_hold cyc %0d got v=%b row=%b out=%h want v=1 row=0 out=%h", i, out_valid, out_row, final_out, pk(10,10,10,10));
      end
    end
    handshake();
    wait_out(e);
    n_cmp++; if (e !== 9 || final_out !== pk(4,4,4,4) || out_row !== 1'b1) begin
      n_bad++; $display("FAIL stall_row1 got lat=%0d out=%h row=%b want lat=9 out=%h row=1", e, final_out, out_row, pk(4,4,4,4));
    end
    handshake();
  endtask

  task automatic test_soft_clr();
    int e;
    bit seen;
    load_t1();
    send_tile();
    wait_out(e);
    handshake();
    repeat (3) step();
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    n_cmp++; if (final_out !== pk(10,10,10,10)) begin n_bad++; $display("FAIL clr_keep_out got %h want %h", final_out, pk(10,10,10,10)); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_no_row1 got 1 want 0"); end
    soft_clr = 1'b1; in_valid = 1'b1;
    step();
    soft_clr = 1'b0; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_blocks_accept got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_no_tile got 1 want 0"); end
    load_cols();
    send_tile();
    wait_out(e);
    n_cmp++; if (final_out !== pk(12,1,0,97)) begin n_bad++; $display("FAIL clr_next_row0 got %h want %h", final_out, pk(12,1,0,97)); end
    handshake();
    wait_out(e);
    n_cmp++; if (final_out !== pk(3,-1,2,65)) begin n_bad++; $display("FAIL clr_next_row1 got %h want %h", final_out, pk(3,-1,2,65)); end
    handshake();
  endtask

  task automatic test_rst_mid();
    int e;
    bit seen;
    load_t1();
    send_tile();
    wait_out(e);
    #2;
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || final_out !== 32'h0) begin
      n_bad++; $display("FAIL rst_async got v=%b out=%h want v=0 out=0", out_valid, final_out);
    end
    repeat (2) step();
    in_valid = 1'b0; rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_output got 1 want 0"); end
    send_tile();
    wait_out(e);
    n_cmp++; if (e !== 9 || final_out !== pk(10,10,10,10)) begin
      n_bad++; $display("FAIL rst_mid_next got lat=%0d out=%h want lat=9 out=%h", e, final_out, pk(10,10,10,10));
    end
    handshake();
    wait_out(e);
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_cols();
    test_sat();
    test_round();
    test_stall();
    test_soft_clr();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
